// File: rtl/ctrl_types_pkg.sv
// Shared types for the cache request arbiter.
//   operation_e : operations a requester can send to the cache controller.
//                 NOP is fixed at encoding 0, so an idle bus reads as NOP.
//   arb_state_e : arbiter FSM states.
//   op_is_legal : 1 when an operation can be forwarded to the controller.
package ctrl_types_pkg;

    typedef enum logic [2:0] {
        NOP    = 3'd0,
        READ   = 3'd1,
        CREATE = 3'd2,
        UPDATE = 3'd3,
        DELETE = 3'd4
    } operation_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_e;

    // NOP and the unused encodings 5..7 are answered locally with an error.
    function automatic logic op_is_legal(operation_e op);
        return (op == READ) || (op == CREATE) || (op == UPDATE) || (op == DELETE);
    endfunction

endpackage

// File: rtl/cache_req_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector
//   last : index of the most recently served requester
//   gnt  : one-hot grant, first set bit searching from last+1 with wrap-around
//   idx  : binary index of gnt
//   any  : 1 when at least one request bit is set
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        // i runs 1..NUM_REQ so the last-served requester is checked last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// Shares one cache controller between NUM_REQ requesters.
// One operation is in flight at a time; requesters are picked round-robin,
// the operation is sent as a one-cycle op_out pulse, and the requester gets a
// one-cycle response pulse when the controller reports done/error or when
// the arbiter gives up after TIMEOUT cycles in WAIT.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-requester request valid
//   req_op       per-requester operation (packed array of operation_e)
//   req_ready    one-hot accept, only ever high in IDLE
//   resp_valid   one-hot response pulse
//   resp_error   qualifies resp_valid: error, timeout or illegal op
//   op_out       operation to the controller, NOP except in ISSUE
//   ctrl_done    controller success pulse (only looked at in WAIT)
//   ctrl_error   controller error pulse (only looked at in WAIT)
//   ctrl_abort   one-cycle pulse on timeout
//   busy         high whenever the FSM is not in IDLE
//   grant_idx    current or last granted requester
//
// state     | meaning
// ----------+---------------------------------------------------------
// ARB_IDLE  | pick a requester, latch its op; illegal op -> ARB_RESP
// ARB_ISSUE | drive op_out for one cycle, clear the timeout counter
// ARB_WAIT  | wait for ctrl_done / ctrl_error, abort at TIMEOUT-1
// ARB_RESP  | pulse resp_valid[g], record g as last grant
module cache_req_arbiter
    import ctrl_types_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  operation_e [NUM_REQ-1:0] req_op,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic                   resp_error,
    output operation_e             op_out,
    input  logic                   ctrl_done,
    input  logic                   ctrl_error,
    output logic                   ctrl_abort,
    output logic                   busy,
    output logic [IDX_W-1:0]       grant_idx
);

    localparam int CNT_W = $clog2(TIMEOUT);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] g_q, g_d;
    logic [IDX_W-1:0] last_q, last_d;
    operation_e       op_q, op_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req  (req_valid),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            g_q     <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            op_q    <= NOP;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            op_q    <= op_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        last_d     = last_q;
        op_d       = op_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        req_ready  = '0;
        resp_valid = '0;
        resp_error = 1'b0;
        op_out     = NOP;
        ctrl_abort = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // The picker only selects valid requesters, so pick_any
                // means the ready bit meets a valid bit: a transfer.
                req_ready = pick_gnt;
                if (pick_any) begin
                    g_d  = pick_idx;
                    op_d = req_op[pick_idx];
                    if (op_is_legal(req_op[pick_idx])) begin
                        err_d   = 1'b0;
                        state_d = ARB_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ARB_RESP;
                    end
                end
            end
            ARB_ISSUE: begin
                op_out  = op_q;
                cnt_d   = '0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Controller status beats the timeout; error beats done.
                if (ctrl_error) begin
                    err_d   = 1'b1;
                    state_d = ARB_RESP;
                end else if (ctrl_done) begin
                    err_d   = 1'b0;
                    state_d = ARB_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    ctrl_abort = 1'b1;
                    err_d      = 1'b1;
                    state_d    = ARB_RESP;
                end
            end
            ARB_RESP: begin
                resp_valid[g_q] = 1'b1;
                resp_error      = err_q;
                last_d          = g_q;
                state_d         = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign busy      = (state_q != ARB_IDLE);
    assign grant_idx = g_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
module tb_cache_req_arbiter;
    import ctrl_types_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 64;
    localparam int IDX_W   = 2;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NUM_REQ-1:0]         req_valid = '0;
    operation_e [NUM_REQ-1:0]   req_op = {READ, READ, READ, READ};
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         resp_valid;
    logic                       resp_error;
    operation_e                 op_out;
    logic                       ctrl_done;
    logic                       ctrl_error;
    logic                       ctrl_abort;
    logic                       busy;
    logic [IDX_W-1:0]           grant_idx;

    logic auto_done = 1'b0, auto_err = 1'b0;
    logic man_done = 1'b0, man_err = 1'b0;
    assign ctrl_done  = auto_done | man_done;
    assign ctrl_error = auto_err  | man_err;

    cache_req_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_error (resp_error),
        .op_out     (op_out),
        .ctrl_done  (ctrl_done),
        .ctrl_error (ctrl_error),
        .ctrl_abort (ctrl_abort),
        .busy       (busy),
        .grant_idx  (grant_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int   idx;
        logic err;
    } resp_t;

    resp_t exp_resp[$];
    int    exp_grant[$];

    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int oh2idx(logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    // Controller model: 0 = done 3 cycles after op, 1 = error 2 cycles after,
    // 2 = silent, 3 = done and error together 2 cycles after.
    int ctl_mode = 0;
    int ctl_cnt  = -1;
    always @(negedge clk) begin
        auto_done = 1'b0;
        auto_err  = 1'b0;
        if (!rst_n) begin
            ctl_cnt = -1;
        end else if (op_out != NOP) begin
            ctl_cnt = (ctl_mode == 0) ? 3 : 2;
        end else if (ctl_cnt > 0) begin
            ctl_cnt--;
            if (ctl_cnt == 0) begin
                case (ctl_mode)
                    0: auto_done = 1'b1;
                    1: auto_err  = 1'b1;
                    3: begin auto_done = 1'b1; auto_err = 1'b1; end
                    default: ;
                endcase
                ctl_cnt = -1;
            end
        end
    end

    // Monitor: grants, issue/abort timing and responses against the queues.
    int n_grants = 0, n_resp = 0, n_ops = 0, n_abort = 0;
    int acc_cyc = 0, resp_cyc = 0, issue_cyc = 0, abort_delta = 0;
    int gidx_exp = 0;
    bit gidx_pend = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (gidx_pend) begin
                check("grant_idx", 32'(grant_idx), 32'(gidx_exp));
                gidx_pend = 1'b0;
            end
            if (req_ready != '0)
                check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
            if ((req_valid & req_ready) != '0) begin
                acc_cyc = cyc;
                n_grants++;
                if (exp_grant.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_grant: got ready=%b expected none", req_ready);
                end else begin
                    gidx_exp = exp_grant.pop_front();
                    check("grant_order", 32'(oh2idx(req_valid & req_ready)), 32'(gidx_exp));
                    gidx_pend = 1'b1;
                end
            end
            if (op_out != NOP) begin
                issue_cyc = cyc;
                n_ops++;
            end
            if (ctrl_abort) begin
                n_abort++;
                abort_delta = cyc - issue_cyc;
            end
            if (resp_valid != '0) begin
                resp_cyc = cyc;
                n_resp++;
                if (exp_resp.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_resp: got resp_valid=%b expected none", resp_valid);
                end else begin
                    resp_t e;
                    e = exp_resp.pop_front();
                    check("resp_valid", 32'(resp_valid), 32'(1) << e.idx);
                    check("resp_error", 32'(resp_error), 32'(e.err));
                end
            end
        end
    end

    task automatic wait_accept();
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) break;
        end
        if (k == 50) begin
            checks++; failures++;
            $display("FAIL accept_timeout: got no req_ready expected accept");
        end
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic wait_idle(int max);
        int k;
        for (k = 0; k < max; k++) begin
            @(negedge clk);
            if (!busy && exp_resp.size() == 0) break;
        end
        if (k == max) begin
            checks++; failures++;
            $display("FAIL idle_timeout: got busy=%0d pending=%0d expected idle", busy, exp_resp.size());
        end
    endtask

    task automatic wait_grants(int target);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (n_grants >= target) break;
        end
        if (k == 200) begin
            checks++; failures++;
            $display("FAIL grant_timeout: got %0d grants expected %0d", n_grants, target);
        end
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic single(int idx, operation_e op, int mode, logic exp_err,
                          int exp_lat, bit exp_abort);
        int abort0;
        abort0 = n_abort;
        ctl_mode = mode;
        exp_grant.push_back(idx);
        exp_resp.push_back('{idx, exp_err});
        @(posedge clk); #1;
        req_op[idx] = op;
        req_valid   = NUM_REQ'(1) << idx;
        wait_accept();
        wait_idle(200);
        check("resp_latency", 32'(resp_cyc - acc_cyc), 32'(exp_lat));
        check("abort_count", 32'(n_abort - abort0), exp_abort ? 32'd1 : 32'd0);
        if (exp_abort) check("abort_delay", 32'(abort_delta), 32'(TIMEOUT));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ops0, resp0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_op_out", 32'(op_out), 32'(NOP));
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_abort", 32'(ctrl_abort), 0);
        check("rst_grant_idx", 32'(grant_idx), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Round robin with all requesters active: 0,1,2,3,0
        ctl_mode = 0;
        for (int i = 0; i < 5; i++) begin
            exp_grant.push_back(i % NUM_REQ);
            exp_resp.push_back('{i % NUM_REQ, 1'b0});
        end
        @(posedge clk); #1;
        req_op    = {READ, READ, READ, READ};
        req_valid = 4'b1111;
        wait_grants(5);
        wait_idle(300);
        check("rr_grants", 32'(n_grants), 5);

        // Requester 2 DELETE, controller error
        single(2, DELETE, 1, 1'b1, 4, 1'b0);
        check("after_err_busy", 32'(busy), 0);

        // Requester 1 CREATE, silent controller -> timeout
        single(1, CREATE, 2, 1'b1, TIMEOUT + 2, 1'b1);

        // Requester 3 NOP: answered locally, nothing issued
        ops0 = n_ops;
        single(3, NOP, 0, 1'b1, 1, 1'b0);
        check("nop_no_issue", 32'(n_ops - ops0), 0);

        // Requester 0 READ with done/error coincident: error wins
        single(0, READ, 3, 1'b1, 4, 1'b0);

        // Stray ctrl_done in IDLE gives no response
        resp0 = n_resp;
        @(posedge clk); #1;
        man_done = 1'b1;
        @(posedge clk); #1;
        man_done = 1'b0;
        repeat (4) @(negedge clk);
        check("stray_done_resp", 32'(n_resp - resp0), 0);
        check("stray_done_busy", 32'(busy), 0);

        // Reset during WAIT drops the operation silently
        ctl_mode = 2;
        exp_grant.push_back(2);
        @(posedge clk); #1;
        req_op[2] = READ;
        req_valid = 4'b0100;
        wait_accept();
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        resp0 = n_resp;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_op_out", 32'(op_out), 32'(NOP));
        check("mid_rst_resp", 32'(resp_valid), 0);
        check("mid_rst_abort", 32'(ctrl_abort), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_no_resp", 32'(n_resp - resp0), 0);

        // After reset requester 0 wins over requester 1
        ctl_mode = 0;
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        exp_resp.push_back('{0, 1'b0});
        exp_resp.push_back('{1, 1'b0});
        @(posedge clk); #1;
        req_op[0] = READ;
        req_op[1] = UPDATE;
        req_valid = 4'b0011;
        wait_grants(n_grants + 2);
        wait_idle(300);
        check("grant_queue_empty", 32'(exp_grant.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
